parking_controller_multi: RTL and testbench
===========================================

// Module: parking_controller_multi
// PURPOSE
//  Next-generation car-park gate controller: parametrised capacity, tag width and authorised-tag table.
//  Per-tag presence tracking, time-stamped entry and an exit lane that computes a saturating parking fee.
//  Sits between the entrance/exit sensors, the RFID reader front-end and the LED/gate drivers.
//  One clock domain; all outputs registered.
// PARAMETERS
//  TAG_W          32   RFID tag width (bits)
//  NUM_TAGS       4    authorised-tag table entries
//  CAPACITY       8    max cars inside; countcar width CNT_W = $clog2(CAPACITY+1)
//  TIMER_W        16   parking-time counter width (units)
//  TICKS_PER_UNIT 100  clk cycles per time unit (prescaler)
//  FEE_PER_UNIT   5    fee charged per elapsed unit
//  FEE_W          16   fee output width
//  RFID_TIMEOUT   16   cycles allowed in WAIT_RFID before auto-deny
//  BLINK_DIV      8    cycles per RED_LED toggle in DENY
// PORTS
//  clk             in   1          system clock, rising edge
//  reset_n         in   1          asynchronous, active-low reset
//  sensor_entrance in   1          car present at entrance gate (level)
//  sensor_exit     in   1          car has cleared entrance gate (level)
//  rfid_valid      in   1          rfid_tag valid this cycle (1-cycle pulse)
//  rfid_tag        in   TAG_W      tag read at entrance
//  prog_we         in   1          write authorised-tag table
//  prog_idx        in   clog2(NUM_TAGS)  table index to write
//  prog_tag        in   TAG_W      tag value; prog_en=1 validates, 0 invalidates entry
//  prog_en         in   1          entry valid bit for write
//  exit_valid      in   1          exit-lane tag presented (1-cycle pulse)
//  exit_tag        in   TAG_W      tag read at exit lane
//  GREEN_LED       out  1          entrance green lamp
//  RED_LED         out  1          entrance red lamp
//  gate_open       out  1          entrance barrier open
//  indicator       out  3          state code: 0 IDLE,1 WAIT_RFID,2 DENY,3 GRANT,4 FULL
//  countcar        out  CNT_W      cars currently inside
//  full            out  1          countcar == CAPACITY
//  fee_valid       out  1          1-cycle pulse, fee valid
//  fee             out  FEE_W      fee of last exiting car (held until next fee_valid)
//  exit_err        out  1          1-cycle pulse: exit_tag not present inside
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, table all invalid, present bits 0, timers 0,
//   countcar 0, fee 0, fee_valid/exit_err/gate_open 0, GREEN_LED 1, RED_LED 0, indicator 0.
//  Time base: prescaler wraps at TICKS_PER_UNIT-1 and increments now_unit (TIMER_W, wraps mod 2^TIMER_W).
//  Match: tag hits entry i if valid[i] && table[i]==tag; lowest index wins. prog_we takes effect next cycle.
//  Entrance FSM (outputs registered from next_state, so they change on the same edge as the state):
//   IDLE      G=1 R=0 gate=0. sensor_entrance=1 -> FULL if full, else WAIT_RFID (timeout cnt cleared).
//   WAIT_RFID G=0 R=1. rfid_valid & hit i & !present[i] -> GRANT; rfid_valid & (miss | present[i]) -> DENY;
//             no rfid_valid after RFID_TIMEOUT cycles in state -> DENY. rfid_valid in other states ignored.
//   GRANT     G=1 R=0 gate=1. On the entering edge: present[i]<=1, entry_time[i]<=now_unit, countcar+1.
//             sensor_exit=1 -> IDLE.
//   DENY      G=0, R toggles every BLINK_DIV cycles (starts at 1). sensor_entrance=0 -> IDLE.
//   FULL      G=0 R=1. sensor_entrance=0 -> IDLE.
//  Exit lane (independent of FSM): on exit_valid, exit_tag hit i & present[i]:
//   present[i]<=0, countcar-1, next cycle fee_valid=1 and
//   fee = min((now_unit-entry_time[i]) mod 2^TIMER_W * FEE_PER_UNIT, 2^FEE_W-1).
//   Otherwise exit_err pulses next cycle; countcar and fee unchanged.
//  Simultaneous GRANT entry and valid exit in one cycle: countcar unchanged (net +1-1).
//  countcar never exceeds CAPACITY (FULL gate) and never underflows (exit requires present bit).
//  Table write to an index with present=1: present cleared, countcar-1, no fee reported.
//  Elapsed time exceeding 2^TIMER_W-1 units aliases (documented limitation).
// TESTING
//  1 Program idx0=0x12345678; entrance=1, rfid 0x12345678 -> GRANT, gate=1, indicator=3, countcar=1.
//  2 Unknown tag 0xDEADBEEF -> DENY, indicator=2, RED toggles every 8 cycles; entrance=0 -> IDLE.
//  3 Enter at unit 10, exit_valid same tag at unit 30 -> fee_valid, fee=100, countcar=0.
//  4 CAPACITY=2, fill 2 tags; 3rd entrance -> FULL, indicator=4, full=1, countcar stays 2.
//  5 No rfid for 16 cycles in WAIT_RFID -> DENY; exit of absent tag -> exit_err, count unchanged.
//  6 Grant and exit same cycle -> countcar unchanged; reset_n low in GRANT -> all outputs reset values.

Source files
------------

// File: rtl/parking_controller_multi.sv
// Car-park gate controller: entrance FSM with RFID authorisation against a
// programmable tag table, per-tag presence and entry time stamps, and an
// independent exit lane that reports a saturating parking fee.
module parking_controller_multi #(
    parameter int TAG_W          = 32,
    parameter int NUM_TAGS       = 4,
    parameter int CAPACITY       = 8,
    parameter int TIMER_W        = 16,
    parameter int TICKS_PER_UNIT = 100,
    parameter int FEE_PER_UNIT   = 5,
    parameter int FEE_W          = 16,
    parameter int RFID_TIMEOUT   = 16,
    parameter int BLINK_DIV      = 8,
    localparam int CNT_W         = $clog2(CAPACITY + 1),
    localparam int IDX_W         = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sensor_entrance,
    input  logic             sensor_exit,
    input  logic             rfid_valid,
    input  logic [TAG_W-1:0] rfid_tag,
    input  logic             prog_we,
    input  logic [IDX_W-1:0] prog_idx,
    input  logic [TAG_W-1:0] prog_tag,
    input  logic             prog_en,
    input  logic             exit_valid,
    input  logic [TAG_W-1:0] exit_tag,
    output logic             GREEN_LED,
    output logic             RED_LED,
    output logic             gate_open,
    output logic [2:0]       indicator,
    output logic [CNT_W-1:0] countcar,
    output logic             full,
    output logic             fee_valid,
    output logic [FEE_W-1:0] fee,
    output logic             exit_err
);

    localparam int PRE_W  = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam int TO_W   = $clog2(RFID_TIMEOUT + 1);
    localparam int BL_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int PROD_W = TIMER_W + 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_RFID = 3'd1,
        DENY      = 3'd2,
        GRANT     = 3'd3,
        FULL      = 3'd4
    } state_t;

    state_t state, next_state;

    logic [PRE_W-1:0]   pre_cnt;
    logic [TIMER_W-1:0] now_unit;
    logic [TO_W-1:0]    to_cnt;
    logic [BL_W-1:0]    blink_cnt;

    logic [TAG_W-1:0]   tag_tbl [NUM_TAGS];
    logic [NUM_TAGS-1:0] tag_vld;
    logic [NUM_TAGS-1:0] present, present_nxt;
    logic [TIMER_W-1:0] entry_time [NUM_TAGS];

    logic               rfid_hit, exit_hit;
    logic [IDX_W-1:0]   rfid_idx, exit_idx;
    logic               grant_ev, exit_ev, prog_clr;
    logic [CNT_W-1:0]   count_nxt;
    logic [TIMER_W-1:0] elapsed;
    logic [PROD_W-1:0]  prod;
    logic [FEE_W-1:0]   fee_sat;
    logic               green_d, red_d, gate_d;

    // Time base: prescaler divides clk down to parking-time units.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt  <= '0;
            now_unit <= '0;
        end else if (pre_cnt == PRE_W'(TICKS_PER_UNIT - 1)) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            pre_cnt  <= '0;
            now_unit <= now_unit + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Tag table valid bits; a write is visible to lookups the next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tag_vld <= '0;
        else if (prog_we) tag_vld[prog_idx] <= prog_en;
    end

    // Tag table storage.
    // NOTE: no reset on the tag storage itself; entries are gated by tag_vld,
    // so their contents after reset are never observed.
    always_ff @(posedge clk) begin
        if (prog_we) tag_tbl[prog_idx] <= prog_tag;
    end

    // Table lookups for entrance and exit readers; lowest index wins.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        rfid_hit = 1'b0;
        rfid_idx = '0;
        exit_hit = 1'b0;
        exit_idx = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (tag_vld[i] && tag_tbl[i] == rfid_tag) begin
                rfid_hit = 1'b1;
                rfid_idx = IDX_W'(i);
            end
            if (tag_vld[i] && tag_tbl[i] == exit_tag) begin
                exit_hit = 1'b1;
                exit_idx = IDX_W'(i);
            end
        end
    end

    // Entrance FSM state register plus registered lamp/gate outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            GREEN_LED <= 1'b1;
            RED_LED   <= 1'b0;
            gate_open <= 1'b0;
            indicator <= 3'd0;
        end else begin
            state     <= next_state;
            GREEN_LED <= green_d;
            RED_LED   <= red_d;
            gate_open <= gate_d;
            indicator <= next_state;
        end
    end

    // Entrance FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (sensor_entrance)
                    next_state = (countcar == CNT_W'(CAPACITY)) ? FULL : WAIT_RFID;
            end
            WAIT_RFID: begin
                if (rfid_valid)
                    next_state = (rfid_hit && !present[rfid_idx]) ? GRANT : DENY;
                else if (to_cnt == TO_W'(RFID_TIMEOUT - 1))
                    next_state = DENY;
            end
            GRANT:       if (sensor_exit) next_state = IDLE;
            DENY, FULL:  if (!sensor_entrance) next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // Output decode from next_state so lamps change on the same edge as the state.
    always_comb begin
        green_d = 1'b0;
        red_d   = 1'b1;
        gate_d  = 1'b0;
        case (next_state)
            IDLE:  begin green_d = 1'b1; red_d = 1'b0; end
            GRANT: begin green_d = 1'b1; red_d = 1'b0; gate_d = 1'b1; end
            DENY: begin
                if (state != DENY)
                    red_d = 1'b1;
                else if (blink_cnt == BL_W'(BLINK_DIV - 1))
                    red_d = ~RED_LED;
                else
                    red_d = RED_LED;
            end
            default: ;
        endcase
    end

    // RFID timeout and DENY blink counters; both restart on state entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt    <= '0;
            blink_cnt <= '0;
        end else begin
            to_cnt <= (state == WAIT_RFID) ? to_cnt + 1'b1 : '0;
            if (state != DENY || blink_cnt == BL_W'(BLINK_DIV - 1))
                blink_cnt <= '0;
            else
                blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Occupancy events, next presence vector, next count and saturating fee.
    always_comb begin
        grant_ev = (state == WAIT_RFID) && (next_state == GRANT);
        exit_ev  = exit_valid && exit_hit && present[exit_idx];
        // A table rewrite evicts the car on that index (including one entering
        // this very cycle), unless the exit lane already removed it.
        prog_clr = prog_we
                 && (present[prog_idx] || (grant_ev && rfid_idx == prog_idx))
                 && !(exit_ev && exit_idx == prog_idx);

        present_nxt = present;
        if (grant_ev) present_nxt[rfid_idx] = 1'b1;
        if (exit_ev)  present_nxt[exit_idx] = 1'b0;
        if (prog_clr) present_nxt[prog_idx] = 1'b0;

        count_nxt = countcar + CNT_W'(grant_ev) - CNT_W'(exit_ev) - CNT_W'(prog_clr);

        elapsed = now_unit - entry_time[exit_idx];
        prod    = PROD_W'(elapsed) * PROD_W'(FEE_PER_UNIT);
        fee_sat = (prod > PROD_W'({FEE_W{1'b1}})) ? {FEE_W{1'b1}} : prod[FEE_W-1:0];
    end

    // Presence, entry time stamps, car count and exit-lane reporting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            present   <= '0;
            for (int i = 0; i < NUM_TAGS; i++) entry_time[i] <= '0;
            countcar  <= '0;
            full      <= 1'b0;
            fee_valid <= 1'b0;
            fee       <= '0;
            exit_err  <= 1'b0;
        end else begin
            present   <= present_nxt;
            if (grant_ev) entry_time[rfid_idx] <= now_unit;
            countcar  <= count_nxt;
            full      <= (count_nxt == CNT_W'(CAPACITY));
            fee_valid <= exit_ev;
            exit_err  <= exit_valid && !exit_ev;
            if (exit_ev) fee <= fee_sat;
        end
    end

endmodule

// File: tb/tb_parking_controller_multi.sv
// Self-checking bench for parking_controller_multi (CAPACITY=2). Exit-lane
// results are predicted into a scoreboard queue when an exit is presented
// and compared when fee_valid / exit_err pulse.
module tb_parking_controller_multi;

    localparam int TAG_W = 32;
    localparam int TICKS = 100;
    localparam int FPU   = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sensor_entrance, sensor_exit, rfid_valid;
    logic [31:0] rfid_tag;
    logic        prog_we, prog_en;
    logic [1:0]  prog_idx;
    logic [31:0] prog_tag;
    logic        exit_valid;
    logic [31:0] exit_tag;
    logic        GREEN_LED, RED_LED, gate_open, full, fee_valid, exit_err;
    logic [2:0]  indicator;
    logic [1:0]  countcar;
    logic [15:0] fee;

    parking_controller_multi #(
        .TAG_W(TAG_W), .NUM_TAGS(4), .CAPACITY(2), .TIMER_W(16),
        .TICKS_PER_UNIT(TICKS), .FEE_PER_UNIT(FPU), .FEE_W(16),
        .RFID_TIMEOUT(16), .BLINK_DIV(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit),
        .rfid_valid(rfid_valid), .rfid_tag(rfid_tag),
        .prog_we(prog_we), .prog_idx(prog_idx), .prog_tag(prog_tag), .prog_en(prog_en),
        .exit_valid(exit_valid), .exit_tag(exit_tag),
        .GREEN_LED(GREEN_LED), .RED_LED(RED_LED), .gate_open(gate_open),
        .indicator(indicator), .countcar(countcar), .full(full),
        .fee_valid(fee_valid), .fee(fee), .exit_err(exit_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference time base: unit count advances every TICKS cycles after reset.
    int m_pre, m_unit;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pre  <= 0;
            m_unit <= 0;
        end else if (m_pre == TICKS - 1) begin
            m_pre  <= 0;
            m_unit <= (m_unit + 1) % 65536;
        end else begin
            m_pre <= m_pre + 1;
        end
    end

    typedef struct {
        logic        is_err;
        logic [15:0] fee;
    } exp_t;
    exp_t sb_q[$];

    // Scoreboard monitor: every exit-lane pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && (fee_valid === 1'b1 || exit_err === 1'b1)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_exit_pulse", {30'd0, fee_valid, exit_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("exit_err", {31'd0, exit_err}, {31'd0, e.is_err});
                check("fee_valid", {31'd0, fee_valid}, {31'd0, !e.is_err});
                if (!e.is_err) check("fee", {16'd0, fee}, {16'd0, e.fee});
            end
        end
    end

    function automatic logic [15:0] calc_fee(input int entry_u, input int now_u);
        int unsigned el;
        int unsigned p;
        el = (now_u - entry_u) & 32'hFFFF;
        p  = el * FPU;
        return (p > 32'hFFFF) ? 16'hFFFF : p[15:0];
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic prog(input logic [1:0] idx, input logic [31:0] tag, input logic en);
        prog_we = 1'b1; prog_idx = idx; prog_tag = tag; prog_en = en;
        step(1);
        prog_we = 1'b0;
    endtask

    task automatic wait_unit(input int u);
        int budget = 0;
        while (m_unit != u && budget < 20000) begin
            step(1);
            budget++;
        end
        if (m_unit != u) check("wait_unit_timeout", m_unit, u);
    endtask

    // Full entry sequence for an authorised tag; returns the entry time unit.
    task automatic enter(input logic [31:0] tag, output int entry_u);
        sensor_entrance = 1'b1;
        step(1);
        rfid_tag = tag; rfid_valid = 1'b1; entry_u = m_unit;
        step(1);
        rfid_valid = 1'b0;
        check("enter_grant_ind", {29'd0, indicator}, 32'd3);
        check("enter_gate", {31'd0, gate_open}, 32'd1);
        sensor_entrance = 1'b0; sensor_exit = 1'b1;
        step(1);
        sensor_exit = 1'b0;
        check("enter_idle_ind", {29'd0, indicator}, 32'd0);
    endtask

    task automatic present_exit(input logic [31:0] tag, input logic is_err, input logic [15:0] f);
        exp_t e;
        e.is_err = is_err; e.fee = f;
        sb_q.push_back(e);
        exit_tag = tag; exit_valid = 1'b1;
        step(1);
        exit_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_green"}, {31'd0, GREEN_LED}, 32'd1);
        check({pfx, "_red"}, {31'd0, RED_LED}, 32'd0);
        check({pfx, "_gate"}, {31'd0, gate_open}, 32'd0);
        check({pfx, "_ind"}, {29'd0, indicator}, 32'd0);
        check({pfx, "_count"}, {30'd0, countcar}, 32'd0);
        check({pfx, "_full"}, {31'd0, full}, 32'd0);
        check({pfx, "_fee"}, {16'd0, fee}, 32'd0);
        check({pfx, "_fee_valid"}, {31'd0, fee_valid}, 32'd0);
        check({pfx, "_exit_err"}, {31'd0, exit_err}, 32'd0);
    endtask

    localparam logic [31:0] TAG_A   = 32'h12345678;
    localparam logic [31:0] TAG_B   = 32'hAAAA0001;
    localparam logic [31:0] TAG_C   = 32'hBBBB0002;
    localparam logic [31:0] TAG_BAD = 32'hDEADBEEF;

    initial begin
        int e_a, e_b, e_c;
        reset_n = 1'b0;
        sensor_entrance = 1'b0; sensor_exit = 1'b0; rfid_valid = 1'b0; rfid_tag = '0;
        prog_we = 1'b0; prog_en = 1'b0; prog_idx = '0; prog_tag = '0;
        exit_valid = 1'b0; exit_tag = '0;
        step(2);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        step(1);

        prog(2'd0, TAG_A, 1'b1);
        prog(2'd1, TAG_B, 1'b1);
        prog(2'd2, TAG_C, 1'b1);

        // Authorised entry at unit 10.
        wait_unit(10);
        sensor_entrance = 1'b1;
        step(1);
        check("wait_ind", {29'd0, indicator}, 32'd1);
        check("wait_green", {31'd0, GREEN_LED}, 32'd0);
        check("wait_red", {31'd0, RED_LED}, 32'd1);
        rfid_tag = TAG_A; rfid_valid = 1'b1; e_a = m_unit;
        step(1);
        rfid_valid = 1'b0;
        check("grant_ind", {29'd0, indicator}, 32'd3);
        check("grant_gate", {31'd0, gate_open}, 32'd1);
        check("grant_green", {31'd0, GREEN_LED}, 32'd1);
        check("grant_red", {31'd0, RED_LED}, 32'd0);
        check("grant_count", {30'd0, countcar}, 32'd1);
        sensor_entrance = 1'b0; sensor_exit = 1'b1;
        step(1);
        sensor_exit = 1'b0;
        check("grant_to_idle_ind", {29'd0, indicator}, 32'd0);
        check("grant_to_idle_gate", {31'd0, gate_open}, 32'd0);

        // Unknown tag: DENY with red blinking every 8 cycles.
        sensor_entrance = 1'b1;
        step(1);
        rfid_tag = TAG_BAD; rfid_valid = 1'b1;
        step(1);
        rfid_valid = 1'b0;
        check("deny_ind", {29'd0, indicator}, 32'd2);
        check("deny_red_start", {31'd0, RED_LED}, 32'd1);
        check("deny_green", {31'd0, GREEN_LED}, 32'd0);
        step(7);
        check("deny_red_hold", {31'd0, RED_LED}, 32'd1);
        step(1);
        check("deny_red_toggle1", {31'd0, RED_LED}, 32'd0);
        step(8);
        check("deny_red_toggle2", {31'd0, RED_LED}, 32'd1);
        sensor_entrance = 1'b0;
        step(1);
        check("deny_to_idle_ind", {29'd0, indicator}, 32'd0);
        check("deny_to_idle_green", {31'd0, GREEN_LED}, 32'd1);

        // Exit at unit 30: fee = 20 units * 5 = 100.
        wait_unit(30);
        present_exit(TAG_A, 1'b0, calc_fee(e_a, m_unit));
        check("exit_a_count", {30'd0, countcar}, 32'd0);

        // Fill to capacity, including a re-presented tag that is already inside.
        enter(TAG_B, e_b);
        check("fill1_count", {30'd0, countcar}, 32'd1);
        sensor_entrance = 1'b1;
        step(1);
        rfid_tag = TAG_B; rfid_valid = 1'b1;
        step(1);
        rfid_valid = 1'b0;
        check("dup_tag_deny_ind", {29'd0, indicator}, 32'd2);
        check("dup_tag_count", {30'd0, countcar}, 32'd1);
        sensor_entrance = 1'b0;
        step(1);
        step(250);
        enter(TAG_C, e_c);
        check("fill2_count", {30'd0, countcar}, 32'd2);
        check("fill2_full", {31'd0, full}, 32'd1);
        sensor_entrance = 1'b1;
        step(1);
        check("full_ind", {29'd0, indicator}, 32'd4);
        check("full_red", {31'd0, RED_LED}, 32'd1);
        check("full_green", {31'd0, GREEN_LED}, 32'd0);
        check("full_count", {30'd0, countcar}, 32'd2);
        sensor_entrance = 1'b0;
        step(1);
        check("full_to_idle_ind", {29'd0, indicator}, 32'd0);

        // Exits of absent tags are rejected; a real exit frees a slot.
        present_exit(TAG_BAD, 1'b1, 16'd0);
        check("err_unknown_count", {30'd0, countcar}, 32'd2);
        present_exit(TAG_A, 1'b1, 16'd0);
        check("err_absent_count", {30'd0, countcar}, 32'd2);
        step(120);
        present_exit(TAG_B, 1'b0, calc_fee(e_b, m_unit));
        check("exit_b_count", {30'd0, countcar}, 32'd1);
        check("exit_b_full", {31'd0, full}, 32'd0);

        // RFID timeout: still waiting after 15 cycles, denied after 16.
        sensor_entrance = 1'b1;
        step(1);
        check("timeout_enter_ind", {29'd0, indicator}, 32'd1);
        step(15);
        check("timeout_wait15_ind", {29'd0, indicator}, 32'd1);
        step(1);
        check("timeout_deny_ind", {29'd0, indicator}, 32'd2);
        sensor_entrance = 1'b0;
        step(1);

        // Simultaneous grant and exit: count unchanged.
        sensor_entrance = 1'b1;
        step(1);
        begin
            exp_t e;
            e.is_err = 1'b0; e.fee = calc_fee(e_c, m_unit);
            sb_q.push_back(e);
        end
        rfid_tag = TAG_A; rfid_valid = 1'b1;
        exit_tag = TAG_C; exit_valid = 1'b1;
        step(1);
        rfid_valid = 1'b0; exit_valid = 1'b0;
        check("simul_count", {30'd0, countcar}, 32'd1);
        check("simul_ind", {29'd0, indicator}, 32'd3);

        // Rewriting the table entry of a car inside evicts it without a fee.
        prog(2'd0, TAG_A, 1'b0);
        check("evict_count", {30'd0, countcar}, 32'd0);
        step(2);

        // Asynchronous reset while in GRANT.
        check("pre_reset_ind", {29'd0, indicator}, 32'd3);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("grant_reset");
        sensor_entrance = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(2);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
